// File: rtl/block_ram_requester.sv
// Request front-end for a 1-cycle-latency block RAM with a 2-entry response FIFO.
// Define BLOCK_RAM_REQUESTER_WRITE_RESPONSE_EN to make writes return the old word.
module block_ram_requester #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqWrite,
  input  logic [ADDR_WIDTH-1:0] reqAddress,
  input  logic [DATA_WIDTH-1:0] reqData,
  output logic                  rspValid,
  input  logic                  rspReady,
  output logic [DATA_WIDTH-1:0] rspData,
  output logic                  ramEnable,
  output logic                  ramWriteEnable,
  output logic [ADDR_WIDTH-1:0] ramAddress,
  output logic [DATA_WIDTH-1:0] ramDataIn,
  input  logic [DATA_WIDTH-1:0] ramDataOut
);

  logic [DATA_WIDTH-1:0] r_mem [2];
  logic [1:0]            r_count;
  logic                  r_wptr;
  logic                  r_rptr;
  logic                  r_inflight;

  logic                  w_accept;
  logic                  w_rsp_req;
  logic                  w_push;
  logic                  w_pop;
  logic [2:0]            w_level;

  assign rspValid = (r_count != 2'd0);
  assign rspData  = r_mem[r_rptr];
  assign w_pop    = rspValid & rspReady;
  assign w_push   = r_inflight;

  // Slots already committed once this cycle's pop is taken into account.
  assign w_level  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign reqReady = ~reset & (w_level < 3'd2);
  assign w_accept = reqValid & reqReady;

  assign ramEnable      = w_accept;
  assign ramWriteEnable = w_accept & reqWrite;
  assign ramAddress     = reqAddress;
  assign ramDataIn      = reqData;

`ifdef BLOCK_RAM_REQUESTER_WRITE_RESPONSE_EN
  assign w_rsp_req = w_accept;
`else
  assign w_rsp_req = w_accept & ~reqWrite;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
    end else begin
      r_inflight <= w_rsp_req;
      if (w_push) begin
        r_mem[r_wptr] <= ramDataOut;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_block_ram_requester.sv
// Scenario bench for block_ram_requester with a behavioural RAM and a response scoreboard.
// Honours BLOCK_RAM_REQUESTER_WRITE_RESPONSE_EN for write-response expectations.
module tb_block_ram_requester;

`ifdef BLOCK_RAM_REQUESTER_WRITE_RESPONSE_EN
  localparam logic WR_RSP = 1'b1;
`else
  localparam logic WR_RSP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [9:0]  reqAddress;
  logic [15:0] reqData;
  logic        rspValid;
  logic        rspReady;
  logic [15:0] rspData;
  logic        ramEnable;
  logic        ramWriteEnable;
  logic [9:0]  ramAddress;
  logic [15:0] ramDataIn;
  logic [15:0] ramDataOut;

  logic [15:0] ram_mem [0:1023];
  logic [15:0] ref_mem [0:1023];
  logic [15:0] sb [$];
  logic [15:0] mon_exp;

  int errors = 0;
  int checks = 0;
  int npops  = 0;

  block_ram_requester #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) dut (
    .clock          (clock),
    .reset          (reset),
    .reqValid       (reqValid),
    .reqReady       (reqReady),
    .reqWrite       (reqWrite),
    .reqAddress     (reqAddress),
    .reqData        (reqData),
    .rspValid       (rspValid),
    .rspReady       (rspReady),
    .rspData        (rspData),
    .ramEnable      (ramEnable),
    .ramWriteEnable (ramWriteEnable),
    .ramAddress     (ramAddress),
    .ramDataIn      (ramDataIn),
    .ramDataOut     (ramDataOut)
  );

  always #5 clock = ~clock;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = 16'(i + 'h100);
      ref_mem[i] = 16'(i + 'h100);
    end
  end

  // Registered read-before-write RAM
  always @(posedge clock) begin
    if (ramEnable) begin
      ramDataOut <= ram_mem[ramAddress];
      if (ramWriteEnable) ram_mem[ramAddress] = ramDataIn;
    end
  end

  // Scoreboard: push on accept, pop and compare on every handshake
  always @(negedge clock) begin
    if (!reset) begin
      if (rspValid && rspReady) begin
        checks++;
        npops++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got rspData=%h, expected no response", rspData);
        end else begin
          mon_exp = sb.pop_front();
          if (rspData !== mon_exp) begin
            errors++;
            $display("FAIL sb_data: got %h, expected %h", rspData, mon_exp);
          end
        end
      end
      if (reqValid && reqReady) begin
        if (!reqWrite || WR_RSP) sb.push_back(ref_mem[reqAddress]);
        if (reqWrite) ref_mem[reqAddress] = reqData;
      end
    end
  end

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || rspValid) && n < 20) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (sb.size() != 0 || rspValid) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending, expected 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; reqValid = 1'b1; reqWrite = 1'b1;
    reqAddress = 10'h3; reqData = 16'hBEEF; rspReady = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({reqReady, ramEnable, ramWriteEnable} !== 3'b000) begin
      errors++;
      $display("FAIL reset_hold: got %b, expected 000", {reqReady, ramEnable, ramWriteEnable});
    end
    reqValid = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({reqReady, rspValid, rspData} !== {1'b1, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b v=%b d=%h, expected 1 0 0000", reqReady, rspValid, rspData);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      reqValid = 1'b1; reqWrite = 1'b0; reqAddress = 10'(i);
      @(negedge clock);
      checks++;
      if (reqReady !== 1'b1) begin
        errors++;
        $display("FAIL b2b_accept%0d: got reqReady=%b, expected 1", i, reqReady);
      end
      if (i >= 2) begin
        checks++;
        if ({rspValid, rspData} !== {1'b1, 16'(i - 2 + 'h100)}) begin
          errors++;
          $display("FAIL b2b_rsp%0d: got %b %h, expected 1 %h", i, rspValid, rspData, 16'(i - 2 + 'h100));
        end
      end
    end
    @(posedge clock); #1 reqValid = 1'b0;
    for (int j = 6; j < 8; j++) begin
      @(negedge clock);
      checks++;
      if ({rspValid, rspData} !== {1'b1, 16'(j + 'h100)}) begin
        errors++;
        $display("FAIL b2b_tail%0d: got %b %h, expected 1 %h", j, rspValid, rspData, 16'(j + 'h100));
      end
    end
    @(negedge clock);
    checks++;
    if (rspValid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty: got rspValid=%b, expected 0", rspValid);
    end
  endtask

  task automatic test_write_read();
    int p0 = npops;
    @(posedge clock); #1;
    reqValid = 1'b1; reqWrite = 1'b1; reqAddress = 10'h5; reqData = 16'h1234;
    @(negedge clock);
    checks++;
    if ({reqReady, ramEnable, ramWriteEnable, ramAddress, ramDataIn} !== {3'b111, 10'h5, 16'h1234}) begin
      errors++;
      $display("FAIL wr_ram_port: got %b %b %b %h %h, expected 1 1 1 005 1234",
               reqReady, ramEnable, ramWriteEnable, ramAddress, ramDataIn);
    end
    @(posedge clock); #1 reqWrite = 1'b0;
    @(negedge clock);
    checks++;
    if ({reqReady, ramEnable, ramWriteEnable} !== 3'b110) begin
      errors++;
      $display("FAIL rd_ram_port: got %b, expected 110", {reqReady, ramEnable, ramWriteEnable});
    end
    @(posedge clock); #1 reqValid = 1'b0;
    @(negedge clock);
    checks++;
    if (rspValid !== WR_RSP) begin
      errors++;
      $display("FAIL wr_rsp_valid: got %b, expected %b", rspValid, WR_RSP);
    end
    @(negedge clock);
    checks++;
    if ({rspValid, rspData} !== {1'b1, 16'h1234}) begin
      errors++;
      $display("FAIL rd_latency: got %b %h, expected 1 1234", rspValid, rspData);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (npops - p0 !== 1 + int'(WR_RSP)) begin
      errors++;
      $display("FAIL wr_rd_count: got %0d, expected %0d", npops - p0, 1 + int'(WR_RSP));
    end
  endtask

  task automatic test_stall();
    int k = 0;
    int p0 = npops;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      rspReady = 1'b0; reqValid = 1'b1; reqWrite = 1'b0;
      reqAddress = 10'(10'h30 + 10'(k));
      @(negedge clock);
      if (reqReady) k++;
    end
    checks++;
    if ({k, reqReady, rspValid, rspData} !== {32'd2, 1'b0, 1'b1, 16'h130}) begin
      errors++;
      $display("FAIL stall_full: got k=%0d rdy=%b v=%b d=%h, expected 2 0 1 0130",
               k, reqReady, rspValid, rspData);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if (rspData !== 16'h130) begin
        errors++;
        $display("FAIL stall_hold%0d: got %h, expected 0130", c, rspData);
      end
    end
    @(posedge clock); #1 rspReady = 1'b1;
    @(negedge clock);
    checks++;
    if (reqReady !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got reqReady=%b, expected 1", reqReady);
    end
    @(posedge clock); #1 reqValid = 1'b0;
    drain("stall");
    checks++;
    if (npops - p0 !== 3) begin
      errors++;
      $display("FAIL stall_count: got %0d, expected 3", npops - p0);
    end
  endtask

  task automatic test_reset_inflight();
    @(posedge clock); #1;
    reqValid = 1'b1; reqWrite = 1'b0; reqAddress = 10'h40;
    @(negedge clock);
    checks++;
    if (reqReady !== 1'b1) begin
      errors++;
      $display("FAIL rsti_accept: got %b, expected 1", reqReady);
    end
    @(posedge clock); #1 reqValid = 1'b0; reset = 1'b1;
    @(negedge clock);
    sb.delete();
    checks++;
    if ({reqReady, rspValid} !== 2'b00) begin
      errors++;
      $display("FAIL rsti_during: got %b, expected 00", {reqReady, rspValid});
    end
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if (reqReady !== 1'b1) begin
      errors++;
      $display("FAIL rsti_release: got %b, expected 1", reqReady);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checks++;
      if (rspValid !== 1'b0) begin
        errors++;
        $display("FAIL rsti_norsp%0d: got %b, expected 0", c, rspValid);
      end
    end
  endtask

  task automatic test_write_response();
    @(posedge clock); #1;
    reqValid = 1'b1; reqWrite = 1'b1; reqAddress = 10'h10; reqData = 16'hAAAA;
    @(posedge clock); #1 reqData = 16'h5555;
    @(posedge clock); #1 reqValid = 1'b0;
    @(negedge clock);
    checks++;
    if ({rspValid, rspValid ? rspData : 16'h0} !== {WR_RSP, WR_RSP ? 16'h0110 : 16'h0}) begin
      errors++;
      $display("FAIL wrsp_first: got %b %h, expected %b", rspValid, rspData, WR_RSP);
    end
    @(negedge clock);
    checks++;
    if ({rspValid, rspValid ? rspData : 16'h0} !== {WR_RSP, WR_RSP ? 16'hAAAA : 16'h0}) begin
      errors++;
      $display("FAIL wrsp_swap: got %b %h, expected %b", rspValid, rspData, WR_RSP);
    end
    drain("wrsp");
    @(posedge clock); #1;
    reqValid = 1'b1; reqWrite = 1'b0; reqAddress = 10'h10;
    @(posedge clock); #1 reqValid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if ({rspValid, rspData} !== {1'b1, 16'h5555}) begin
      errors++;
      $display("FAIL wrsp_readback: got %b %h, expected 1 5555", rspValid, rspData);
    end
    drain("wrsp_rd");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_write_read();
    test_stall();
    test_reset_inflight();
    test_write_response();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
